// File: rtl/count_event_gen.sv
// Threshold compare / event generator fed by an external counter's count_value.
// Produces a registered waveform, per-period event pulse and a divided sticky interrupt.
module count_event_gen #(
  parameter int WIDTH = 10,
  parameter int EVW   = 8
) (
  input  logic             clk,
  input  logic             sreset_n,
  input  logic             clken,
  input  logic [WIDTH-1:0] count_value,
  input  logic             start,
  input  logic             stop,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] on_value,
  input  logic [WIDTH-1:0] off_value,
  input  logic [WIDTH-1:0] period_value,
  input  logic             upd_req,
  input  logic [EVW-1:0]   evt_div,
  input  logic             irq_clr,
  output logic             wave_out,
  output logic             period_evt,
  output logic             irq_status,
  output logic             upd_pend,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] on_act, off_act, period_act;
  logic [EVW-1:0]   evt_cnt;
  logic             m_on, m_off, m_per;
  logic [EVW:0]     evt_inc, div_eff;

  // A stalled counter (clken low) must not re-trigger on a held value.
  always_comb begin
    m_on    = clken && (count_value == on_act);
    m_off   = clken && (count_value == off_act);
    m_per   = clken && (count_value == period_act);
    evt_inc = {1'b0, evt_cnt} + 1'b1;
    div_eff = (evt_div == '0) ? {{EVW{1'b0}}, 1'b1} : {1'b0, evt_div};
  end

  always_ff @(posedge clk) begin
    if (!sreset_n) begin
      state      <= IDLE;
      on_act     <= '0;
      off_act    <= '0;
      period_act <= '0;
      evt_cnt    <= '0;
      wave_out   <= 1'b0;
      period_evt <= 1'b0;
      irq_status <= 1'b0;
      upd_pend   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      period_evt <= 1'b0;
      if (upd_req) upd_pend   <= 1'b1;
      if (irq_clr) irq_status <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        wave_out <= 1'b0;
        busy     <= 1'b0;
        evt_cnt  <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state      <= ARMED;
              busy       <= 1'b1;
              on_act     <= on_value;
              off_act    <= off_value;
              period_act <= period_value;
              upd_pend   <= 1'b0;
            end
          end
          ARMED: begin
            if (m_per) state <= RUN;
          end
          RUN: begin
            // Clear wins when on and off coincide.
            if (m_off)     wave_out <= 1'b0;
            else if (m_on) wave_out <= 1'b1;
            if (m_per) begin
              period_evt <= 1'b1;
              // Later assignment keeps irq set ahead of a same-cycle irq_clr.
              if (evt_inc >= div_eff) begin
                evt_cnt    <= '0;
                irq_status <= 1'b1;
              end else begin
                evt_cnt <= evt_inc[EVW-1:0];
              end
              if (upd_pend) begin
                on_act     <= on_value;
                off_act    <= off_value;
                period_act <= period_value;
                upd_pend   <= 1'b0;
              end
              if (one_shot) begin
                state    <= DONE;
                busy     <= 1'b0;
                wave_out <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
